// File: rtl/srt_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : srt_pkg                                                       |
// | Brief    : Shared constants and FSM encodings for the SRT pre-normaliser |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package srt_pkg;

    localparam int W = 8;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;

    localparam logic [7:0] D_NORM_MIN = 8'h40;
    localparam logic [7:0] D_NORM_MAX = 8'h7F;

endpackage
`default_nettype wire

// File: rtl/srt_lzc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : srt_lzc                                                       |
// | Brief    : Leading-zero priority encoder counting down from bit W-2      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module srt_lzc #(
    parameter int W    = 8,
    parameter int SH_W = 3
) (
    input  logic [W-2:0]    v,
    output logic [SH_W-1:0] cnt
);

    // Ascending scan: the highest set bit is the last to write, so it wins.
    always_comb begin
        cnt = '0;
        for (int i = 0; i <= W-2; i++) begin
            if (v[i]) cnt = SH_W'(W-2-i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/srt_prenorm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : srt_prenorm                                                   |
// | Brief    : Divisor/dividend pre-normalisation ahead of the radix-4 SRT   |
// |            divider. Define SRT_PRENORM_FAST_EN for single-cycle shifting.|
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module srt_prenorm #(
    parameter int W    = 8,
    parameter int SH_W = 3
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    n_in,
    input  logic [W-1:0]    d_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    n_norm,
    output logic [W-1:0]    d_norm,
    output logic [SH_W-1:0] shamt,
    output logic            err_dz,
    output logic            err_range,
    output logic            err_ovf,
    output logic            div_start
);

    import srt_pkg::*;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [W-1:0]    r_n;
    logic [W-1:0]    r_d;
    logic [SH_W-1:0] r_shamt;
    logic            r_err_dz;
    logic            r_err_range;
    logic            r_err_ovf;
    logic            w_dz;
    logic            w_range;

    assign w_dz    = (d_in == '0);
    assign w_range = d_in[W-1];

`ifdef SRT_PRENORM_FAST_EN
    logic [SH_W-1:0] w_lz;
    logic [SH_W-1:0] w_lz_eff;
    logic [2*W-1:0]  w_n_wide;

    srt_lzc #(.W(W), .SH_W(SH_W)) u_lzc (
        .v   (d_in[W-2:0]),
        .cnt (w_lz)
    );

    // Illegal divisors are passed through unshifted, matching the iterative build.
    assign w_lz_eff = (w_dz || w_range) ? '0 : w_lz;
    assign w_n_wide = {{W{1'b0}}, n_in} << w_lz_eff;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
`ifdef SRT_PRENORM_FAST_EN
                    w_state_nxt = ST_HOLD;
`else
                    w_state_nxt = (w_dz || w_range) ? ST_HOLD : ST_SHIFT;
`endif
                end
            end
            ST_SHIFT: if (r_d[W-2]) w_state_nxt = ST_HOLD;
            ST_HOLD:  if (out_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_HOLD);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_n         <= '0;
            r_d         <= '0;
            r_shamt     <= '0;
            r_err_dz    <= 1'b0;
            r_err_range <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_err_dz    <= w_dz;
                        r_err_range <= !w_dz && w_range;
`ifdef SRT_PRENORM_FAST_EN
                        r_n       <= w_n_wide[W-1:0];
                        r_d       <= d_in << w_lz_eff;
                        r_shamt   <= w_lz_eff;
                        r_err_ovf <= |w_n_wide[2*W-1:W];
`else
                        r_n       <= n_in;
                        r_d       <= d_in;
                        r_shamt   <= '0;
                        r_err_ovf <= 1'b0;
`endif
                    end
                end
                ST_SHIFT: begin
                    if (!r_d[W-2]) begin
                        r_d     <= r_d << 1;
                        r_n     <= r_n << 1;
                        r_shamt <= r_shamt + 1'b1;
                        if (r_n[W-1]) r_err_ovf <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign n_norm    = r_n;
    assign d_norm    = r_d;
    assign shamt     = r_shamt;
    assign err_dz    = r_err_dz;
    assign err_range = r_err_range;
    assign err_ovf   = r_err_ovf;
    assign div_start = out_valid && out_ready && !(r_err_dz || r_err_range || r_err_ovf);

endmodule
`default_nettype wire

// File: tb/tb_srt_prenorm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_srt_prenorm                                                |
// | Brief    : Directed-vector bench for srt_prenorm                         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_srt_prenorm;

    logic       clk = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] n_in;
    logic [7:0] d_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] n_norm;
    logic [7:0] d_norm;
    logic [2:0] shamt;
    logic       err_dz;
    logic       err_range;
    logic       err_ovf;
    logic       div_start;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    srt_prenorm #(.W(8), .SH_W(3)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n_in      (n_in),
        .d_in      (d_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .n_norm    (n_norm),
        .d_norm    (d_norm),
        .shamt     (shamt),
        .err_dz    (err_dz),
        .err_range (err_range),
        .err_ovf   (err_ovf),
        .div_start (div_start)
    );

    typedef struct {
        logic [7:0] n;
        logic [7:0] d;
        logic [7:0] en;
        logic [7:0] ed;
        logic [2:0] sh;
        logic       dz;
        logic       rng;
        logic       ovf;
        int         s;      // shift count, -1 for an error case
    } vec_t;

    vec_t vecs[10];

    function automatic logic [31:0] result_word();
        return {10'd0, n_norm, d_norm, shamt, err_dz, err_range, err_ovf};
    endfunction

    function automatic logic [31:0] exp_word(input vec_t v);
        return {10'd0, v.en, v.ed, v.sh, v.dz, v.rng, v.ovf};
    endfunction

    function automatic int exp_lat(input int s);
`ifdef SRT_PRENORM_FAST_EN
        return 0;
`else
        return (s < 0) ? 0 : s + 1;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Present a pair for one accept edge; returns with time at E0 + 1.
    task automatic offer(input logic [7:0] n, input logic [7:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        n_in     = n;
        d_in     = d;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic handshake(input logic exp_start);
        check("div_start_before_ready", 32'(div_start), 32'd0);
        out_ready = 1'b1;
        #1;
        check("div_start_in_handshake", 32'(div_start), 32'(exp_start));
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("after_handshake", {29'd0, out_valid, div_start, in_ready}, 32'b001);
    endtask

    initial begin
        int lat;
        logic [31:0] held;

        vecs[0] = '{8'h01, 8'h03, 8'h20, 8'h60, 3'd5, 1'b0, 1'b0, 1'b0, 5};
        vecs[1] = '{8'h35, 8'h40, 8'h35, 8'h40, 3'd0, 1'b0, 1'b0, 1'b0, 0};
        vecs[2] = '{8'h12, 8'h00, 8'h12, 8'h00, 3'd0, 1'b1, 1'b0, 1'b0, -1};
        vecs[3] = '{8'h12, 8'h90, 8'h12, 8'h90, 3'd0, 1'b0, 1'b1, 1'b0, -1};
        vecs[4] = '{8'h50, 8'h05, 8'h00, 8'h50, 3'd4, 1'b0, 1'b0, 1'b1, 4};
        vecs[5] = '{8'h03, 8'h01, 8'hC0, 8'h40, 3'd6, 1'b0, 1'b0, 1'b0, 6};
        vecs[6] = '{8'h81, 8'h20, 8'h02, 8'h40, 3'd1, 1'b0, 1'b0, 1'b1, 1};
        vecs[7] = '{8'hFF, 8'h80, 8'hFF, 8'h80, 3'd0, 1'b0, 1'b1, 1'b0, -1};
        vecs[8] = '{8'h7F, 8'h7F, 8'h7F, 8'h7F, 3'd0, 1'b0, 1'b0, 1'b0, 0};
        vecs[9] = '{8'hC3, 8'h0F, 8'h18, 8'h78, 3'd3, 1'b0, 1'b0, 1'b1, 3};

        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_in      = '0;
        d_in      = '0;
        #1;
        check("reset_outputs", {result_word()[30:0], out_valid}, 32'd0);
        check("reset_ready_start", {30'd0, in_ready, div_start}, 32'b10);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            offer(vecs[i].n, vecs[i].d);
            wait_valid(lat);
            check($sformatf("latency_v%0d", i), 32'(lat), 32'(exp_lat(vecs[i].s)));
            check($sformatf("result_v%0d", i), result_word(), exp_word(vecs[i]));
            check($sformatf("in_ready_hold_v%0d", i), 32'(in_ready), 32'd0);
            handshake(!(vecs[i].dz || vecs[i].rng || vecs[i].ovf));
        end

        // Backpressure: 0x10/0x10 needs two shifts.
        offer(8'h10, 8'h10);
        wait_valid(lat);
        held = result_word();
        check("bp_result", held, {10'd0, 8'h40, 8'h40, 3'd2, 3'b000});
        repeat (3) begin
            @(posedge clk);
            #1;
            check("bp_stable", result_word(), held);
            check("bp_flags", {29'd0, out_valid, in_ready, div_start}, 32'b100);
        end

        // New pair offered during the handshake must wait one cycle.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        n_in      = 8'h35;
        d_in      = 8'h40;
        #1;
        check("bp_div_start", 32'(div_start), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("overlap_not_taken", {30'd0, out_valid, in_ready}, 32'b01);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("overlap_taken", 32'(in_ready), 32'd0);
        wait_valid(lat);
        check("overlap_result", result_word(), {10'd0, 8'h35, 8'h40, 3'd0, 3'b000});
        handshake(1'b1);

        // Asynchronous reset in the middle of an operation.
        offer(8'h01, 8'h01);
        @(posedge clk);
        #1;
        check("busy_before_reset", 32'(in_ready), 32'd0);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_outputs", {result_word()[30:0], out_valid}, 32'd0);
        check("async_reset_flags", {30'd0, in_ready, div_start}, 32'b10);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_reset", {30'd0, in_ready, out_valid}, 32'b10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
